// File: rtl/tlul_host_arb_if.sv
// Bundles the host-side and device-side TL-UL handshakes of tlul_host_arb.
// "slave" is the arbiter's view; "master" is the view of whatever drives it.
interface tlul_host_arb_if #(
    parameter int NumHosts       = 2,
    parameter int AWidth         = 101,
    parameter int DWidth         = 65,
    parameter int MaxOutstanding = 3
);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic [NumHosts-1:0]        a_valid_i;
    logic [NumHosts*AWidth-1:0] a_data_i;
    logic [NumHosts-1:0]        a_ready_o;
    logic                       a_valid_o;
    logic [AWidth-1:0]          a_data_o;
    logic                       a_ready_i;
    logic                       d_valid_i;
    logic [DWidth-1:0]          d_data_i;
    logic                       d_ready_o;
    logic [NumHosts-1:0]        d_valid_o;
    logic [DWidth-1:0]          d_data_o;
    logic [NumHosts-1:0]        d_ready_i;
    logic [CntW-1:0]            outstanding_o;
    logic                       unexpected_o;

    modport slave (
        input  a_valid_i, a_data_i, a_ready_i, d_valid_i, d_data_i, d_ready_i,
        output a_ready_o, a_valid_o, a_data_o, d_ready_o, d_valid_o, d_data_o,
               outstanding_o, unexpected_o
    );

    modport master (
        output a_valid_i, a_data_i, a_ready_i, d_valid_i, d_data_i, d_ready_i,
        input  a_ready_o, a_valid_o, a_data_o, d_ready_o, d_valid_o, d_data_o,
               outstanding_o, unexpected_o
    );
endinterface

// File: rtl/tlul_host_arb.sv
// N:1 TL-UL host arbiter: round-robin A grant with lock, in-order tracking FIFO
// steering D responses back, and a cap on in-flight requests.
module tlul_host_arb #(
    parameter int NumHosts       = 2,
    parameter int AWidth         = 101,
    parameter int DWidth         = 65,
    parameter int MaxOutstanding = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    tlul_host_arb_if.slave bus
);
    localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [IdxW-1:0] LastHost = IdxW'(NumHosts - 1);
    localparam logic [PtrW-1:0] LastSlot = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] Depth    = CntW'(MaxOutstanding);

    logic [IdxW-1:0] rr_ptr_reg;
    logic            lock_reg;
    logic [IdxW-1:0] lock_idx_reg;
    logic [PtrW-1:0] wr_ptr_reg;
    logic [PtrW-1:0] rd_ptr_reg;
    logic [CntW-1:0] count_reg;
    logic [CntW-1:0] count_next;
    logic            unexpected_reg;
    logic [IdxW-1:0] fifo_mem [MaxOutstanding];

    logic [IdxW-1:0] cand_idx [NumHosts];
    logic [NumHosts-1:0] cand_valid;
    logic [IdxW-1:0] rr_pick;
    logic [IdxW-1:0] grant;
    logic [IdxW-1:0] head;
    logic            can_accept;
    logic            nonempty;
    logic            a_valid;
    logic            a_hs;
    logic            d_ready;
    logic            d_hs;

    // Candidate at offset gi from the round-robin pointer, wrapped modulo NumHosts.
    for (genvar gi = 0; gi < NumHosts; gi++) begin : g_cand
        logic [IdxW:0] sum;
        assign sum            = {1'b0, rr_ptr_reg} + (IdxW+1)'(gi);
        assign cand_idx[gi]   = (sum >= (IdxW+1)'(NumHosts)) ?
                                IdxW'(sum - (IdxW+1)'(NumHosts)) : IdxW'(sum);
        assign cand_valid[gi] = bus.a_valid_i[cand_idx[gi]];
    end

    // Walk offsets from farthest to nearest so the nearest valid host wins.
    always_comb begin
        rr_pick = rr_ptr_reg;
        for (int k = NumHosts - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                rr_pick = cand_idx[k];
            end
        end
    end

    assign grant      = lock_reg ? lock_idx_reg : rr_pick;
    assign can_accept = (count_reg < Depth);
    assign nonempty   = (count_reg != '0);
    assign head       = fifo_mem[rd_ptr_reg];

    assign a_valid        = !rst_i && can_accept && bus.a_valid_i[grant];
    assign a_hs           = a_valid && bus.a_ready_i;
    assign bus.a_valid_o  = a_valid;
    assign bus.a_data_o   = bus.a_data_i[grant*AWidth +: AWidth];

    assign d_ready        = !rst_i && nonempty && bus.d_ready_i[head];
    assign d_hs           = bus.d_valid_i && d_ready;
    assign bus.d_ready_o  = d_ready;
    assign bus.d_data_o   = bus.d_data_i;

    for (genvar gi = 0; gi < NumHosts; gi++) begin : g_host
        assign bus.a_ready_o[gi] = !rst_i && can_accept && bus.a_ready_i &&
                                   (grant == IdxW'(gi));
        assign bus.d_valid_o[gi] = !rst_i && nonempty && bus.d_valid_i &&
                                   (head == IdxW'(gi));
    end

    assign bus.outstanding_o = count_reg;
    assign bus.unexpected_o  = unexpected_reg;

    always_comb begin
        count_next = count_reg;
        case ({a_hs, d_hs})
            2'b10:   count_next = count_reg + CntW'(1);
            2'b01:   count_next = count_reg - CntW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_reg     <= '0;
            lock_reg       <= 1'b0;
            lock_idx_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            unexpected_reg <= 1'b0;
        end else begin
            if (a_hs) begin
                wr_ptr_reg <= (wr_ptr_reg == LastSlot) ? '0 : wr_ptr_reg + PtrW'(1);
                rr_ptr_reg <= (grant == LastHost) ? '0 : grant + IdxW'(1);
                lock_reg   <= 1'b0;
            end else if (a_valid) begin
                lock_reg     <= 1'b1;
                lock_idx_reg <= grant;
            end
            if (d_hs) begin
                rd_ptr_reg <= (rd_ptr_reg == LastSlot) ? '0 : rd_ptr_reg + PtrW'(1);
            end
            if (bus.d_valid_i && !nonempty) begin
                unexpected_reg <= 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Entries are only read while counted, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && a_hs) begin
            fifo_mem[wr_ptr_reg] <= grant;
        end
    end
endmodule

// File: tb/tb_tlul_host_arb.sv
// Self-checking bench for tlul_host_arb: vector table for arbitration/flow,
// scoreboard queue of granted hosts for D routing, hand sequences for lock/reset.
module tb_tlul_host_arb;
    localparam int NH = 2;
    localparam int AW = 101;
    localparam int DW = 65;
    localparam int MO = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tlul_host_arb_if #(.NumHosts(NH), .AWidth(AW), .DWidth(DW), .MaxOutstanding(MO)) bus ();

    tlul_host_arb #(.NumHosts(NH), .AWidth(AW), .DWidth(DW), .MaxOutstanding(MO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [NH-1:0] av;
        logic          ar;
        logic          dv;
        logic [NH-1:0] dr;
        logic          exp_aval;
        int            exp_grant;
        int            exp_out;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int sb_q[$];
    logic [AW-1:0] hd [NH];
    logic [DW-1:0] dpay;
    vec_t tbl [17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [NH-1:0] av, input logic ar, input logic dv,
                         input logic [NH-1:0] dr);
        bus.a_valid_i = av;
        bus.a_ready_i = ar;
        bus.d_valid_i = dv;
        bus.d_ready_i = dr;
    endtask

    // D side expectation comes from the scoreboard head.
    task automatic check_d(input logic dv, input logic [NH-1:0] dr);
        logic [NH-1:0] exp_v;
        logic          exp_r;
        int            h;
        exp_v = '0;
        exp_r = 1'b0;
        h     = 0;
        if (sb_q.size() != 0) begin
            h     = sb_q[0];
            exp_v = dv ? NH'(1 << h) : '0;
            exp_r = dr[h];
        end
        check("d_valid_o", bus.d_valid_o, exp_v);
        check("d_ready_o", bus.d_ready_o, exp_r);
        if (dv && exp_r) begin
            check("d_data_o", bus.d_data_o, dpay);
            void'(sb_q.pop_front());
            $display("D response -> host %0d", h);
        end
    endtask

    task automatic check_a(input logic exp_aval, input int g, input int exp_out, input logic ar);
        logic [NH-1:0] exp_rdy;
        exp_rdy = (exp_out < MO && ar) ? NH'(1 << g) : '0;
        check("a_valid_o", bus.a_valid_o, exp_aval);
        check("a_ready_o", bus.a_ready_o, exp_rdy);
        check("outstanding_o", bus.outstanding_o, exp_out);
        if (exp_aval) check("a_data_o", bus.a_data_o, hd[g]);
        if (exp_aval && ar) begin
            sb_q.push_back(g);
            $display("A accept host %0d (outstanding %0d)", g, exp_out);
        end
    endtask

    task automatic step(input logic [NH-1:0] av, input logic ar, input logic dv,
                        input logic [NH-1:0] dr, input logic exp_aval, input int g,
                        input int exp_out);
        apply(av, ar, dv, dr);
        @(negedge clk);
        check_d(dv, dr);
        check_a(exp_aval, g, exp_out, ar);
        @(posedge clk);
        #1;
    endtask

    initial begin
        hd[0] = AW'(101'h0A_0000_BEEF_0000);
        hd[1] = AW'(101'h1B_0000_CAFE_0001);
        dpay  = DW'(65'h1_2345_6789_ABCD_EF01);
        bus.a_data_i = {hd[1], hd[0]};
        bus.d_data_i = dpay;
        apply('0, 1'b0, 1'b0, '0);

        // av, ar, dv, dr, exp_aval, exp_grant, exp_out
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 0, 0};
        tbl[1]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1, 1};
        tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 0, 1};
        tbl[3]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1, 1};
        tbl[4]  = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 0, 1};
        tbl[5]  = '{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 0, 0};
        tbl[6]  = '{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 0, 1};
        tbl[7]  = '{2'b10, 1'b1, 1'b0, 2'b11, 1'b1, 1, 2};
        tbl[8]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 0, 3};
        tbl[9]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 0, 3};
        tbl[10] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 0, 2};
        tbl[11] = '{2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1, 3};
        tbl[12] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1, 3};
        tbl[13] = '{2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1, 3};
        tbl[14] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1, 2};
        tbl[15] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1, 1};
        tbl[16] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1, 0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset outstanding_o", bus.outstanding_o, 0);
        check("reset unexpected_o", bus.unexpected_o, 1'b0);
        check("reset a_valid_o", bus.a_valid_o, 1'b0);
        check("reset d_valid_o", bus.d_valid_o, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            $display("vector %0d: av=%b ar=%b dv=%b dr=%b", i, tbl[i].av, tbl[i].ar,
                     tbl[i].dv, tbl[i].dr);
            step(tbl[i].av, tbl[i].ar, tbl[i].dv, tbl[i].dr,
                 tbl[i].exp_aval, tbl[i].exp_grant, tbl[i].exp_out);
        end
        check("unexpected_o after table", bus.unexpected_o, 1'b0);

        // Lock: host 1 stalled three cycles, host 0 raises valid meanwhile.
        step(2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 1, 0);
        step(2'b10, 1'b0, 1'b1, 2'b11, 1'b1, 1, 1);
        step(2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1, 0);
        step(2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1, 0);
        step(2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 1, 0);
        step(2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 0, 1);

        // Reset with two requests outstanding; handshakes are masked during reset.
        apply(2'b11, 1'b1, 1'b1, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("in-reset a_valid_o", bus.a_valid_o, 1'b0);
        check("in-reset a_ready_o", bus.a_ready_o, 0);
        check("in-reset d_valid_o", bus.d_valid_o, 0);
        check("in-reset d_ready_o", bus.d_ready_o, 1'b0);
        check("pre-reset outstanding_o", bus.outstanding_o, 2);
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        apply('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("post-reset outstanding_o", bus.outstanding_o, 0);
        check("post-reset unexpected_o", bus.unexpected_o, 1'b0);
        @(posedge clk);
        #1;

        // Stray response with an empty tracking FIFO.
        apply(2'b00, 1'b0, 1'b1, 2'b11);
        @(negedge clk);
        check_d(1'b1, 2'b11);
        check("stray unexpected_o same cycle", bus.unexpected_o, 1'b0);
        @(posedge clk);
        #1 apply('0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("stray unexpected_o", bus.unexpected_o, 1'b1);
        check("stray outstanding_o", bus.outstanding_o, 0);
        @(posedge clk);
        @(negedge clk);
        check("sticky unexpected_o", bus.unexpected_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
